cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the accumulator-mode CPU. It sequences the instruction decoder, the register file and a single shared memory port. It fetches an instruction into its instruction register, presents it to `decode_instruction`, and executes NOP, ADD, LI, LR, SR and HALT through fetch / decode / execute / memory states. Fetches and data accesses arbitrate for the one memory port by time-multiplexing.

---
 rtl/cpu_sequencer_if.sv | 23 ++
 rtl/cpu_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
interface cpu_sequencer_if #(
  parameter int INSTRUCTION_WIDTH = 28,
  parameter int DATA_WIDTH        = 16,
  parameter int ADDR_WIDTH        = 12
);
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0]        mem_wdata;
  logic [INSTRUCTION_WIDTH-1:0] mem_rdata;
  logic                         mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the accumulator-mode CPU: fetch / decode /
// execute / memory, sharing one memory port between fetches and data access.
module cpu_sequencer #(
  parameter int INSTRUCTION_WIDTH = 28,
  parameter int WIDTH_OPCODE      = 5,
  parameter int REGFILE_ADDR_BITS = 5,
  parameter int IMMEDIATE_WIDTH   = 8,
  parameter int DATA_WIDTH        = 16,
  parameter int ADDR_WIDTH        = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic [WIDTH_OPCODE-1:0]      opcode,
  input  logic [REGFILE_ADDR_BITS-1:0] reg_dest,
  input  logic [REGFILE_ADDR_BITS-1:0] reg_source,
  input  logic [IMMEDIATE_WIDTH-1:0]   immediate,
  output logic [REGFILE_ADDR_BITS-1:0] rf_raddr_a,
  output logic [REGFILE_ADDR_BITS-1:0] rf_raddr_b,
  input  logic [DATA_WIDTH-1:0]        rf_rdata_a,
  input  logic [DATA_WIDTH-1:0]        rf_rdata_b,
  output logic                         rf_we,
  output logic [REGFILE_ADDR_BITS-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  cpu_sequencer_if.master              mem,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic                         halted,
  output logic                         illegal
);

  localparam logic [WIDTH_OPCODE-1:0] OP_NOP  = WIDTH_OPCODE'(5'd0);
  localparam logic [WIDTH_OPCODE-1:0] OP_ADD  = WIDTH_OPCODE'(5'd1);
  localparam logic [WIDTH_OPCODE-1:0] OP_LR   = WIDTH_OPCODE'(5'd2);
  localparam logic [WIDTH_OPCODE-1:0] OP_SR   = WIDTH_OPCODE'(5'd3);
  localparam logic [WIDTH_OPCODE-1:0] OP_LI   = WIDTH_OPCODE'(5'd6);
  localparam logic [WIDTH_OPCODE-1:0] OP_HALT = WIDTH_OPCODE'(5'd31);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_HALTED  = 3'd5
  } state_t;

  state_t                       state_q, state_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic                         is_store_q, is_store_d;
  logic                         illegal_q, illegal_d;

  logic                         wr_cand_s;
  logic [DATA_WIDTH-1:0]        wr_data_s;
  logic                         mem_req_s;
  logic                         mem_we_s;
  logic [ADDR_WIDTH-1:0]        mem_addr_s;

  // State and datapath registers; async reset clears everything to IDLE/zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      pc_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_store_q <= is_store_d;
      illegal_q  <= illegal_d;
    end
  end

  // Next-state, memory-port and register-write decisions for each state.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_store_d = is_store_q;
    illegal_d  = illegal_q;
    wr_cand_s  = 1'b0;
    wr_data_s  = '0;
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    // Idle address is the latched data address so it reads zero after reset
    mem_addr_s = addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        mem_req_s  = 1'b1;
        mem_addr_s = pc_q;
        if (mem.mem_ack) begin
          instr_d = mem.mem_rdata;
          pc_d    = pc_q + ADDR_WIDTH'(1'b1);
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        case (opcode)
          OP_NOP: begin
            state_d = S_FETCH;
          end
          OP_ADD: begin
            wr_cand_s = 1'b1;
            wr_data_s = rf_rdata_a + rf_rdata_b;
            state_d   = S_FETCH;
          end
          OP_LI: begin
            wr_cand_s = 1'b1;
            wr_data_s = DATA_WIDTH'(immediate);
            state_d   = S_FETCH;
          end
          OP_LR: begin
            addr_d     = rf_rdata_b[ADDR_WIDTH-1:0] + ADDR_WIDTH'(immediate);
            is_store_d = 1'b0;
            state_d    = S_MEM;
          end
          OP_SR: begin
            addr_d     = rf_rdata_a[ADDR_WIDTH-1:0] + ADDR_WIDTH'(immediate);
            wdata_d    = rf_rdata_b;
            is_store_d = 1'b1;
            state_d    = S_MEM;
          end
          OP_HALT: begin
            state_d = S_HALTED;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALTED;
          end
        endcase
      end

      S_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = is_store_q;
        if (mem.mem_ack) begin
          if (!is_store_q) begin
            wr_cand_s = 1'b1;
            wr_data_s = mem.mem_rdata[DATA_WIDTH-1:0];
          end else begin
            wr_cand_s = 1'b0;
          end
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory port is decoded straight from the state register so reset drops
  // the request without waiting for a clock edge.
  assign mem.mem_req   = mem_req_s;
  assign mem.mem_we    = mem_we_s;
  assign mem.mem_addr  = mem_addr_s;
  assign mem.mem_wdata = wdata_q;

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign halted      = (state_q == S_HALTED);
  assign illegal     = illegal_q;

  assign rf_raddr_a = reg_dest;
  assign rf_raddr_b = reg_source;

  // R0 is hard-wired to zero, so a write aimed at it is suppressed.
  assign rf_we    = wr_cand_s && (reg_dest != '0);
  assign rf_waddr = wr_cand_s ? reg_dest : '0;
  assign rf_wdata = wr_data_s;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with decoder, register
// file and wait-state memory models.
module tb_cpu_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [27:0] instruction;
  logic [4:0]  opcode;
  logic [4:0]  reg_dest;
  logic [4:0]  reg_source;
  logic [7:0]  immediate;
  logic [4:0]  rf_raddr_a, rf_raddr_b;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [11:0] pc;
  logic        halted;
  logic        illegal;

  cpu_sequencer_if mem_if ();

  cpu_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .instruction (instruction),
    .opcode      (opcode),
    .reg_dest    (reg_dest),
    .reg_source  (reg_source),
    .immediate   (immediate),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .mem         (mem_if),
    .pc          (pc),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  // Decoder model: opcode[27:23], dest[22:18], source[17:13], imm[7:0]
  assign opcode     = instruction[27:23];
  assign reg_dest   = instruction[22:18];
  assign reg_source = instruction[17:13];
  assign immediate  = instruction[7:0];

  // Register file model with a preload path driven by the stimulus
  logic [15:0] rf [0:31];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = 5'd0;
  logic [15:0] pre_data = 16'h0000;
  assign rf_rdata_a = (rf_raddr_a == 5'd0) ? 16'h0000 : rf[rf_raddr_a];
  assign rf_rdata_b = (rf_raddr_b == 5'd0) ? 16'h0000 : rf[rf_raddr_b];

  always @(posedge clock) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  // Memory model: program image written by stimulus, stores captured by monitor
  logic [27:0] mem [0:4095];
  int          wait_n = 0;
  int          wcnt;
  logic        st_valid;
  logic [11:0] st_addr;
  logic [15:0] st_data;

  assign mem_if.mem_ack   = mem_if.mem_req && (wcnt >= wait_n);
  assign mem_if.mem_rdata = (st_valid && (mem_if.mem_addr == st_addr)) ?
                            {12'h000, st_data} : mem[mem_if.mem_addr];

  always @(posedge clock or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (mem_if.mem_req && !mem_if.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Monitor: write/request counters and hold-stability while a request waits
  logic        clr = 1'b1;
  int          we_cnt, r0_cnt, req_cnt, st_cnt, unstable;
  logic        pend;
  logic        p_we;
  logic [11:0] p_addr;
  logic [15:0] p_wdata;

  always @(negedge clock) begin
    if (clr) begin
      we_cnt <= 0; r0_cnt <= 0; req_cnt <= 0; st_cnt <= 0; unstable <= 0;
      st_valid <= 1'b0; st_addr <= 12'h000; st_data <= 16'h0000;
    end else begin
      if (rf_we) we_cnt <= we_cnt + 1;
      if (rf_we && rf_waddr == 5'd0) r0_cnt <= r0_cnt + 1;
      if (mem_if.mem_req) req_cnt <= req_cnt + 1;
      if (mem_if.mem_req && mem_if.mem_we && mem_if.mem_ack) begin
        st_cnt   <= st_cnt + 1;
        st_addr  <= mem_if.mem_addr;
        st_data  <= mem_if.mem_wdata;
        st_valid <= 1'b1;
      end
      if (pend && (!mem_if.mem_req || mem_if.mem_we != p_we ||
                   mem_if.mem_addr != p_addr || mem_if.mem_wdata != p_wdata))
        unstable <= unstable + 1;
    end
    pend    <= mem_if.mem_req && !mem_if.mem_ack;
    p_we    <= mem_if.mem_we;
    p_addr  <= mem_if.mem_addr;
    p_wdata <= mem_if.mem_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start and count clock edges until halted (bounded)
  task automatic run_prog(input int bound, output int cyc);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    cyc = 0;
    while (!halted && cyc < bound) begin
      @(negedge clock);
      cyc++;
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic clear_log();
    clr = 1'b1;
    @(negedge clock);
    #1 clr = 1'b0;
  endtask

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    @(negedge clock); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock); pre_we = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 28'h0000000;
  endtask

  int cyc;

  initial begin
    clear_mem();
    for (int i = 0; i < 32; i++) begin
      preload(5'(i), 16'h0000);
    end

    // Reset state
    @(negedge clock);
    chk("rst_instruction", instruction, 28'h0);
    chk("rst_pc", pc, 12'h0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 16'h0);
    chk("rst_mem_req", mem_if.mem_req, 1'b0);
    chk("rst_mem_we", mem_if.mem_we, 1'b0);
    chk("rst_mem_addr", mem_if.mem_addr, 12'h0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 16'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);

    // Reset asserted mid-fetch drops mem_req without a clock edge
    reset = 1'b0;
    wait_n = 5;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("fetch_req", mem_if.mem_req, 1'b1);
    chk("fetch_addr0", mem_if.mem_addr, 12'h000);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_req_drop", mem_if.mem_req, 1'b0);
    @(negedge clock); reset = 1'b0; wait_n = 0;
    @(negedge clock);
    chk("idle_after_rst_req", mem_if.mem_req, 1'b0);

    // LI/ADD program
    mem[0] = 28'h3140014;
    mem[1] = 28'h3200016;
    mem[2] = 28'h0A0A000;
    mem[3] = 28'hF800000;
    clear_log();
    run_prog(100, cyc);
    chk("liadd_cycles", cyc, 12);
    chk("liadd_r5", rf[5], 16'h0014);
    chk("liadd_r8", rf[8], 16'h002A);
    chk("liadd_pc", pc, 12'h004);
    chk("liadd_halted", halted, 1'b1);
    chk("liadd_ir", instruction, 28'hF800000);
    chk("liadd_we_cnt", we_cnt, 3);

    // start is ignored once halted
    clear_log();
    @(negedge clock); start = 1'b1;
    repeat (4) @(negedge clock);
    start = 1'b0;
    #1;
    chk("halt_start_req", req_cnt, 0);
    chk("halt_start_halted", halted, 1'b1);
    chk("halt_start_pc", pc, 12'h004);

    // Store then load through the shared port
    pulse_reset();
    mem[0] = 28'h1810030;
    mem[1] = 28'h1080030;
    mem[2] = 28'hF800000;
    clear_log();
    run_prog(100, cyc);
    chk("srlr_cycles", cyc, 11);
    chk("srlr_st_cnt", st_cnt, 1);
    chk("srlr_st_addr", st_addr, 12'h030);
    chk("srlr_st_data", st_data, 16'h002A);
    chk("srlr_r2", rf[2], 16'h002A);
    chk("srlr_pc", pc, 12'h003);

    // Wait states on fetch and store
    pulse_reset();
    mem[0] = 28'h1810030;
    mem[1] = 28'hF800000;
    wait_n = 3;
    clear_log();
    run_prog(200, cyc);
    chk("wait_cycles", cyc, 16);
    chk("wait_st_cnt", st_cnt, 1);
    chk("wait_st_addr", st_addr, 12'h030);
    chk("wait_unstable", unstable, 0);
    chk("wait_pc", pc, 12'h002);
    wait_n = 0;

    // R0 never written, ADD wraps, PC wraps past 0xFFF
    pulse_reset();
    clear_mem();
    mem[0]     = 28'h3000005;
    mem[1]     = 28'h08C8000;
    mem[12'hFFF] = 28'hF800000;
    preload(5'd3, 16'hFFFF);
    preload(5'd4, 16'h0001);
    clear_log();
    run_prog(20000, cyc);
    chk("wrap_cycles", cyc, 12288);
    chk("wrap_pc", pc, 12'h000);
    chk("wrap_add_r3", rf[3], 16'h0000);
    chk("wrap_r0_writes", r0_cnt, 0);
    chk("wrap_r0_value", rf[0], 16'h0000);
    chk("wrap_we_cnt", we_cnt, 1);

    // Illegal opcode
    pulse_reset();
    mem[0] = 28'h3800000;
    clear_log();
    run_prog(100, cyc);
    chk("ill_cycles", cyc, 3);
    chk("ill_illegal", illegal, 1'b1);
    chk("ill_halted", halted, 1'b1);
    clear_log();
    @(negedge clock); start = 1'b1;
    repeat (5) @(negedge clock);
    start = 1'b0;
    #1;
    chk("ill_no_req", req_cnt, 0);
    chk("ill_still_halted", halted, 1'b1);
    pulse_reset();
    #1;
    chk("ill_cleared_by_reset", illegal, 1'b0);
    chk("halted_cleared_by_reset", halted, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
